// File: rtl/ecc_dec_out_stage.sv
// rtl/ecc_dec_out_stage.sv - ECC decoder output buffer with error statistics and uncorrectable irq
module ecc_dec_out_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int AMBA_WORD  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_decoded_word,
    input  logic [1:0]            in_err_num,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_err_num,
    input  logic                  cnt_clr,
    input  logic                  irq_clr,
    output logic [AMBA_WORD-1:0]  word_cnt,
    output logic [AMBA_WORD-1:0]  corr_cnt,
    output logic [AMBA_WORD-1:0]  uncorr_cnt,
    output logic                  irq_uncorr
);

    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic [1:0]            head_err;
    logic [DATA_WIDTH-1:0] tail_data;
    logic [1:0]            tail_err;

    logic [CNT_WIDTH-1:0]  word_q;
    logic [CNT_WIDTH-1:0]  corr_q;
    logic [CNT_WIDTH-1:0]  uncorr_q;
    logic                  irq_q;

    logic push;
    logic pop;
    logic is_corr;
    logic is_uncorr;

    // Handshakes depend only on registered occupancy, never on out_ready
    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign is_corr   = (in_err_num == 2'b01);
    assign is_uncorr = in_err_num[1];

    assign out_data    = head_data;
    assign out_err_num = head_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            occ       <= 2'd0;
            head_data <= '0;
            head_err  <= 2'b00;
            tail_data <= '0;
            tail_err  <= 2'b00;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        head_data <= in_decoded_word;
                        head_err  <= in_err_num;
                        occ       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_data <= in_decoded_word;
                        head_err  <= in_err_num;
                    end else if (push) begin
                        tail_data <= in_decoded_word;
                        tail_err  <= in_err_num;
                        occ       <= 2'd2;
                    end else if (pop) begin
                        occ       <= 2'd0;
                    end
                end
                2'd2: begin
                    // Full: in_ready is low, so only a pop can happen here
                    if (pop) begin
                        head_data <= tail_data;
                        head_err  <= tail_err;
                        occ       <= 2'd1;
                    end
                end
                default: begin
                    occ <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            word_q   <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (cnt_clr) begin
            word_q   <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (push) begin
            if (word_q != '1) begin
                word_q <= word_q + 1'b1;
            end
            if (is_corr && (corr_q != '1)) begin
                corr_q <= corr_q + 1'b1;
            end
            if (is_uncorr && (uncorr_q != '1)) begin
                uncorr_q <= uncorr_q + 1'b1;
            end
        end
    end

    // A new uncorrectable word must never be lost to a coincident clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_q <= 1'b0;
        end else if (push && is_uncorr) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_uncorr = irq_q;

    always_comb begin
        word_cnt                   = '0;
        corr_cnt                   = '0;
        uncorr_cnt                 = '0;
        word_cnt[CNT_WIDTH-1:0]    = word_q;
        corr_cnt[CNT_WIDTH-1:0]    = corr_q;
        uncorr_cnt[CNT_WIDTH-1:0]  = uncorr_q;
    end

endmodule

// File: tb/tb_ecc_dec_out_stage.sv
// tb/tb_ecc_dec_out_stage.sv - directed self-checking bench for ecc_dec_out_stage
module tb_ecc_dec_out_stage;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_decoded_word;
    logic [1:0]    in_err_num;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_err_num;
    logic          cnt_clr;
    logic          irq_clr;
    logic [AW-1:0] word_cnt;
    logic [AW-1:0] corr_cnt;
    logic [AW-1:0] uncorr_cnt;
    logic          irq_uncorr;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    ecc_dec_out_stage #(
        .DATA_WIDTH(DW),
        .AMBA_WORD (AW),
        .CNT_WIDTH (CW)
    ) dut (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_decoded_word(in_decoded_word),
        .in_err_num     (in_err_num),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_err_num    (out_err_num),
        .cnt_clr        (cnt_clr),
        .irq_clr        (irq_clr),
        .word_cnt       (word_cnt),
        .corr_cnt       (corr_cnt),
        .uncorr_cnt     (uncorr_cnt),
        .irq_uncorr     (irq_uncorr)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] e);
        in_valid        = v;
        in_decoded_word = d;
        in_err_num      = e;
    endtask

    task automatic check_cnts(input string tag, input int w, input int c, input int u);
        check({tag, "_word"},   word_cnt,   32'(w));
        check({tag, "_corr"},   corr_cnt,   32'(c));
        check({tag, "_uncorr"}, uncorr_cnt, 32'(u));
    endtask

    initial begin
        PRESETn   = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        irq_clr   = 1'b0;
        drive(1'b0, 32'h0, 2'b00);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();

        // Reset then idle
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_out_data",  out_data,        32'h0);
        check("rst_out_err",   32'(out_err_num), 32'd0);
        check_cnts("rst", 0, 0, 0);
        check("rst_irq",       32'(irq_uncorr), 32'd0);

        // Streaming with out_ready held high
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_00A5, 2'b00);
        tick();
        check("s1_valid", 32'(out_valid),   32'd1);
        check("s1_data",  out_data,         32'h0000_00A5);
        check("s1_err",   32'(out_err_num), 32'd0);
        drive(1'b1, 32'h0000_0123, 2'b01);
        tick();
        check("s2_data",  out_data,         32'h0000_0123);
        check("s2_err",   32'(out_err_num), 32'd1);
        drive(1'b1, 32'h03FF_FFFF, 2'b10);
        tick();
        check("s3_data",  out_data,         32'h03FF_FFFF);
        check("s3_err",   32'(out_err_num), 32'd2);
        drive(1'b0, 32'h0, 2'b00);
        tick();
        check("s_drained", 32'(out_valid), 32'd0);
        check_cnts("s", 3, 1, 1);
        check("s_irq", 32'(irq_uncorr), 32'd1);

        // Clear counters and irq alone
        cnt_clr = 1'b1;
        irq_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        irq_clr = 1'b0;
        check_cnts("clr", 0, 0, 0);
        check("clr_irq", 32'(irq_uncorr), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 2'b00);
        tick();
        check("bp1_ready", 32'(in_ready), 32'd1);
        check("bp1_data",  out_data,      32'h11);
        drive(1'b1, 32'h22, 2'b00);
        tick();
        check("bp2_ready", 32'(in_ready), 32'd0);
        check("bp2_data",  out_data,      32'h11);
        drive(1'b1, 32'h33, 2'b00);
        tick();
        check("bp3_ready", 32'(in_ready), 32'd0);
        check("bp3_data",  out_data,      32'h11);
        check("bp3_word",  word_cnt,      32'd2);
        drive(1'b0, 32'h0, 2'b00);
        out_ready = 1'b1;
        tick();
        check("bp_pop1_data",  out_data,      32'h22);
        check("bp_pop1_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_pop2_valid", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at occupancy 1
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 2'b00);
        tick();
        check("pp_head", out_data, 32'h11);
        out_ready = 1'b1;
        drive(1'b1, 32'h44, 2'b00);
        tick();
        check("pp_data",  out_data,       32'h44);
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_ready", 32'(in_ready),  32'd1);
        drive(1'b0, 32'h0, 2'b00);
        tick();
        check("pp_empty", 32'(out_valid), 32'd0);
        check("pp_word",  word_cnt,       32'd4);

        // Saturation at 2^CW-1
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'(i), 2'b01);
            tick();
        end
        check_cnts("sat", 15, 15, 0);

        // cnt_clr has priority over a push; irq still sets from that push
        cnt_clr = 1'b1;
        drive(1'b1, 32'h55, 2'b10);
        tick();
        cnt_clr = 1'b0;
        drive(1'b0, 32'h0, 2'b00);
        check_cnts("clrpush", 0, 0, 0);
        check("clrpush_irq", 32'(irq_uncorr), 32'd1);

        irq_clr = 1'b1;
        tick();
        check("irqclr", 32'(irq_uncorr), 32'd0);
        drive(1'b1, 32'h66, 2'b10);
        tick();
        irq_clr = 1'b0;
        check("irq_set_wins", 32'(irq_uncorr), 32'd1);
        drive(1'b1, 32'h77, 2'b11);
        tick();
        check_cnts("err11", 2, 0, 2);

        // Async reset with buffer full
        drive(1'b0, 32'h0, 2'b00);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h88, 2'b00);
        tick();
        drive(1'b1, 32'h99, 2'b00);
        tick();
        drive(1'b0, 32'h0, 2'b00);
        check("ar_full", 32'(in_ready), 32'd0);
        #2;
        PRESETn = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid),  32'd0);
        check("ar_data",  out_data,        32'h0);
        check_cnts("ar", 0, 0, 0);
        check("ar_irq",   32'(irq_uncorr), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        check("ar_in_ready", 32'(in_ready),  32'd1);
        check("ar_empty",    32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
